// File: rtl/pc_debug_tracker.sv
// Shadow PC pipeline (D/E/M/W) producing the writeback commit trace of the 5-stage core.
// Optional retire counter enabled by defining PC_TRACE_RETIRE_CNT_EN.
module pc_debug_tracker #(
    parameter int PC_W = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [PC_W-1:0] i_if_pc,
    input  logic            i_if_vld,
    input  logic            i_hold_id,
    input  logic            i_flush,
    input  logic            i_illegal_id,
    output logic [PC_W-1:0] o_pc_debug,
    output logic            o_insn_vld,
    output logic [31:0]     o_retire_cnt
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            vld;
        logic            ill;
    } entry_t;

    localparam entry_t BUBBLE = '{pc: {PC_W{1'b0}}, vld: 1'b0, ill: 1'b0};

    entry_t          d_q, d_d;
    entry_t          e_q, e_d;
    entry_t          m_q, m_d;
    entry_t          w_q, w_d;
    logic [PC_W-1:0] pc_debug_q, pc_debug_d;
    logic            insn_vld_q, insn_vld_d;

    // Stage advance: flush beats hold; the entry already in EX always moves on to M.
    always_comb begin
        d_d        = d_q;
        e_d        = BUBBLE;
        m_d        = e_q;
        w_d        = m_q;
        pc_debug_d = w_q.pc;
        insn_vld_d = w_q.vld & ~w_q.ill;

        if (i_flush) begin
            d_d = BUBBLE;
        end else if (i_hold_id) begin
            d_d = d_q;
        end else begin
            d_d.pc  = i_if_vld ? i_if_pc : {PC_W{1'b0}};
            d_d.vld = i_if_vld;
            d_d.ill = 1'b0;
        end

        if (i_flush || i_hold_id) begin
            e_d = BUBBLE;
        end else begin
            e_d.pc  = d_q.pc;
            e_d.vld = d_q.vld;
            e_d.ill = d_q.vld & i_illegal_id;
        end
    end

    // Stage and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            d_q        <= BUBBLE;
            e_q        <= BUBBLE;
            m_q        <= BUBBLE;
            w_q        <= BUBBLE;
            pc_debug_q <= {PC_W{1'b0}};
            insn_vld_q <= 1'b0;
        end else begin
            d_q        <= d_d;
            e_q        <= e_d;
            m_q        <= m_d;
            w_q        <= w_d;
            pc_debug_q <= pc_debug_d;
            insn_vld_q <= insn_vld_d;
        end
    end

    assign o_pc_debug = pc_debug_q;
    assign o_insn_vld = insn_vld_q;

`ifdef PC_TRACE_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // Keyed on the next o_insn_vld so the count moves on the same edge as the retirement.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (insn_vld_d) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Retire counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            retire_cnt_q <= 32'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign o_retire_cnt = retire_cnt_q;
`else
    assign o_retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pc_debug_tracker.sv
// Bench for pc_debug_tracker: directed vector table, hand-written reset/counter sequences,
// and randomized hold/flush/illegal/reset traffic against a retire-schedule model.
module tb_pc_debug_tracker;

    localparam int PC_W = 32;
    localparam int NRAND = 2000;
`ifdef PC_TRACE_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] if_pc;
    logic            if_vld, hold, flush, ill;
    logic [PC_W-1:0] pc_dbg;
    logic            insn_vld;
    logic [31:0]     retire_cnt;

    always #5 clk = ~clk;

    pc_debug_tracker #(.PC_W(PC_W)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_if_pc     (if_pc),
        .i_if_vld    (if_vld),
        .i_hold_id   (hold),
        .i_flush     (flush),
        .i_illegal_id(ill),
        .o_pc_debug  (pc_dbg),
        .o_insn_vld  (insn_vld),
        .o_retire_cnt(retire_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        r;
        logic [31:0] pc;
        logic        v, h, f, il;
        logic [31:0] epc;
        logic        ev;
    } vec_t;

    vec_t tbl[34];

    // Expected WB trace per edge index for the random phase.
    logic [31:0] xpc [0:NRAND+8];
    logic        xv  [0:NRAND+8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, take the edge, and settle before sampling.
    task automatic step(input logic r, input logic [31:0] pc, input logic v,
                        input logic h, input logic f, input logic il);
        rst = r; if_pc = pc; if_vld = v; hold = h; flush = f; ill = il;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [31:0] pc, input logic v,
                                input logic h, input logic f, input logic il,
                                input logic [31:0] epc, input logic ev);
        vec_t t;
        t.r = r; t.pc = pc; t.v = v; t.h = h; t.f = f; t.il = il; t.epc = epc; t.ev = ev;
        return t;
    endfunction

    initial begin
        logic [31:0] cnt_exp;
        logic [31:0] id_pc;
        logic        id_vld;
        logic        r, v, h, f, il;
        logic [31:0] pc;

        rst = 1'b1; if_pc = 32'h0; if_vld = 1'b0; hold = 1'b0; flush = 1'b0; ill = 1'b0;

        //            rst   pc            v     h     f     il    exp_pc        exp_vld
        tbl[0]  = mk(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[1]  = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[2]  = mk(1'b0, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[3]  = mk(1'b0, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[4]  = mk(1'b0, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[5]  = mk(1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        tbl[6]  = mk(1'b0, 32'h0000_0014, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 1'b1);
        tbl[7]  = mk(1'b0, 32'h0000_0014, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1);
        tbl[8]  = mk(1'b0, 32'h0000_0018, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b1);
        tbl[9]  = mk(1'b0, 32'h0000_001C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[10] = mk(1'b0, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1);
        tbl[11] = mk(1'b0, 32'h0000_0024, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0014, 1'b1);
        tbl[12] = mk(1'b0, 32'h0000_0028, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0018, 1'b1);
        tbl[13] = mk(1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_001C, 1'b1);
        tbl[14] = mk(1'b0, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 1'b1);
        tbl[15] = mk(1'b0, 32'h0000_0108, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[16] = mk(1'b0, 32'h0000_010C, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
        tbl[17] = mk(1'b0, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b1);
        tbl[18] = mk(1'b0, 32'h0000_0204, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0104, 1'b1);
        tbl[19] = mk(1'b0, 32'h0000_166C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[20] = mk(1'b0, 32'h0000_1670, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
        tbl[21] = mk(1'b0, 32'h0000_1674, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b1);
        tbl[22] = mk(1'b0, 32'h0000_0999, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0204, 1'b1);
        tbl[23] = mk(1'b0, 32'h0000_1678, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_166C, 1'b0);
        tbl[24] = mk(1'b0, 32'h0000_167C, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1670, 1'b1);
        tbl[25] = mk(1'b0, 32'h0000_167C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1674, 1'b1);
        tbl[26] = mk(1'b0, 32'h0000_1680, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[27] = mk(1'b0, 32'h0000_1684, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[28] = mk(1'b0, 32'h0000_1688, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1678, 1'b1);
        tbl[29] = mk(1'b1, 32'h0000_168C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[30] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[31] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[32] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
        tbl[33] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);

        // Directed table.
        cnt_exp = 32'd0;
        for (int i = 0; i < 34; i++) begin
            step(tbl[i].r, tbl[i].pc, tbl[i].v, tbl[i].h, tbl[i].f, tbl[i].il);
            if (tbl[i].r) cnt_exp = 32'd0;
            else if (tbl[i].ev) cnt_exp = cnt_exp + 32'd1;
            check($sformatf("tbl%0d_pc", i), pc_dbg, tbl[i].epc);
            check($sformatf("tbl%0d_vld", i), {31'd0, insn_vld}, {31'd0, tbl[i].ev});
            check($sformatf("tbl%0d_cnt", i), retire_cnt, CNT_EN ? cnt_exp : 32'd0);
        end

        // Reset with three instructions in flight after five retirements.
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b0, 32'h0000_3000 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_last_pc", pc_dbg, 32'h0000_3014);
        check("mid_cnt_before", retire_cnt, CNT_EN ? 32'd5 : 32'd0);
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("mid_rst%0d_pc", i), pc_dbg, 32'h0);
            check($sformatf("mid_rst%0d_vld", i), {31'd0, insn_vld}, 32'd0);
            check($sformatf("mid_rst%0d_cnt", i), retire_cnt, 32'd0);
            step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

`ifdef PC_TRACE_RETIRE_CNT_EN
        // Counter wrap from a forced preload.
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        step(1'b0, 32'h0000_4000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0000_4004, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_hold_cnt", retire_cnt, 32'hFFFF_FFFF);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_cnt0", retire_cnt, 32'h0000_0000);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_cnt1", retire_cnt, 32'h0000_0001);
`endif

        // Random phase: each edge decides what leaves decode and schedules its WB slot 3 edges on.
        for (int k = 0; k <= NRAND + 8; k++) begin
            xpc[k] = 32'h0;
            xv[k]  = 1'b0;
        end
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        id_pc = 32'h0; id_vld = 1'b0; cnt_exp = 32'd0;
        for (int k = 1; k <= NRAND; k++) begin
            r  = ($urandom_range(0, 63) == 0);
            v  = ($urandom_range(0, 4) != 0);
            h  = ($urandom_range(0, 4) == 0);
            f  = ($urandom_range(0, 7) == 0);
            il = ($urandom_range(0, 3) == 0);
            pc = $urandom;
            if (r) begin
                for (int j = k; j <= k + 3; j++) begin
                    xpc[j] = 32'h0;
                    xv[j]  = 1'b0;
                end
                id_pc = 32'h0; id_vld = 1'b0;
            end else begin
                if (!f && !h) begin
                    xpc[k+3] = id_pc;
                    xv[k+3]  = id_vld & ~il;
                end
                if (f) begin
                    id_pc = 32'h0; id_vld = 1'b0;
                end else if (!h) begin
                    id_pc = v ? pc : 32'h0; id_vld = v;
                end
            end
            if (r) cnt_exp = 32'd0;
            else if (xv[k]) cnt_exp = cnt_exp + 32'd1;
            step(r, pc, v, h, f, il);
            check($sformatf("rnd%0d_pc", k), pc_dbg, xpc[k]);
            check($sformatf("rnd%0d_vld", k), {31'd0, insn_vld}, {31'd0, xv[k]});
            check($sformatf("rnd%0d_cnt", k), retire_cnt, CNT_EN ? cnt_exp : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
